mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CPU, default 2, number of CPU ports (range 1..4).
REQ-002 SHALL have parameter ADDR_W, default 10, word-address width of the memory.
REQ-003 SHALL have parameter DATA_W, default 32, data width; must be a multiple of 8.
REQ-004 SHALL have parameter RR_MODE, default 1: 1 = round-robin among CPU ports; 0 = fixed priority, lower index wins.
REQ-005 SHALL have parameter STARVE_MAX, default 15, host-port wait limit in cycles (range 1..255).
REQ-006 SHALL have the following ports. One clock; reset is synchronous and active-low.
- mips_cpu_clk  in  1  sole clock, rising edge.
- mips_cpu_resetn  in  1  synchronous active-low reset.
- cpu_hold  in  1  high while the CPUs are held in reset; CPU requests are ignored.
- cpu_req  in  NUM_CPU  per-CPU access request.
- cpu_we  in  NUM_CPU  per-CPU write enable.
- cpu_addr  in  NUM_CPU*ADDR_W  packed word addresses.
- cpu_wdata  in  NUM_CPU*DATA_W  packed write data.
- cpu_wstrb  in  NUM_CPU*DATA_W/8  packed byte strobes.
- cpu_gnt  out  NUM_CPU  one-hot grant; the access is accepted this cycle.
- cpu_rvalid  out  NUM_CPU  read data valid, one cycle after the read grant.
- cpu_rdata  out  DATA_W  read data, shared by all CPU ports, qualified by cpu_rvalid.
- host_req, host_we  in  1  host (AXI-Lite side) request and write enable.
- host_addr  in  ADDR_W;  host_wdata  in  DATA_W;  host_wstrb  in  DATA_W/8.
- host_gnt, host_rvalid  out  1;  host_rdata  out  DATA_W.
- mem_en  out  1;  mem_we  out  DATA_W/8 byte writes;  mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W.
- mem_rdata  in  DATA_W  synchronous-read data, valid one cycle after mem_en with mem_we==0.

Function
REQ-007 Exactly one port (or none) SHALL be granted per cycle; all grant outputs SHALL be combinational from the requests and the arbiter state.
REQ-008 Requesters SHALL hold req/we/addr/wdata/wstrb stable until granted; a grant consumes exactly one access.
REQ-009 When cpu_hold=1, cpu_req SHALL be masked and a host_req SHALL be granted in the same cycle.
REQ-010 When cpu_hold=0, host SHALL be lowest priority unless the starvation counter equals STARVE_MAX, in which case host SHALL win over all CPU ports.
REQ-011 The starvation counter (8-bit, saturating) SHALL increment each cycle host_req=1 and host_gnt=0, and SHALL clear on host_gnt or host_req=0.
REQ-012 RR_MODE=1: the round-robin pointer SHALL advance to one past the granted CPU index (mod NUM_CPU) on each CPU grant; the search starts at the pointer and wraps. The pointer SHALL hold on host grants and idle cycles.
REQ-013 On a grant, mem_en=1, mem_addr/mem_wdata SHALL mux from the winner, and mem_we SHALL equal the winner's wstrb if we=1, else 0; with no grant, mem_en=0 and mem_we=0.
REQ-014 For a read grant, the winner's rvalid SHALL pulse one cycle later with rdata=mem_rdata; a one-bit-per-port return register records the winner.
REQ-015 Writes SHALL produce no rvalid. cpu_rdata/host_rdata SHALL be 0 when the corresponding rvalid=0.
REQ-016 Back-to-back grants every cycle SHALL be supported (full throughput, no bubbles).
REQ-017 If cpu_hold rises while a CPU read return is pending, the return SHALL still complete next cycle.

Reset
REQ-018 While mips_cpu_resetn=0 at a clock edge: grants, rvalids and mem_en/mem_we SHALL be 0 next cycle; the pointer, counter and return register SHALL clear; pending returns SHALL be dropped.
REQ-019 During reset, the combinational grants SHALL be forced to 0.

Structure
REQ-020 A shared package mem_arb_pkg SHALL hold the port-index type, the STARVE counter width (8) and the RR_MODE constants.
REQ-021 Sub-module rr_picker (parametrised one-hot round-robin select from requests + pointer) SHALL be instantiated once; fixed priority SHALL reuse it with the pointer tied to 0.

Verification
REQ-022 NUM_CPU=2, RR_MODE=1, both CPUs read continuously -> grants alternate 0,1,0,1; each rvalid follows its grant by exactly 1 cycle.
REQ-023 cpu_hold=1, host writes addr 5 data 0xA5A5A5A5 wstrb 0xF, both CPUs requesting -> host_gnt same cycle, mem_we=0xF, no cpu_gnt.
REQ-024 cpu_hold=0, CPU0 requests every cycle, host requests with STARVE_MAX=3 -> host granted on its 4th waiting cycle, counter clears.
REQ-025 RR_MODE=0, both CPUs request -> CPU0 always granted; CPU1 never granted while CPU0 requests.
REQ-026 CPU1 read granted, mips_cpu_resetn=0 on the next edge -> no cpu_rvalid, all outputs 0; after release the first grant goes to CPU0.
REQ-027 Byte write wstrb=0x2 to addr 0 -> mem_we=0x2; a following read returns the merged byte from the memory model.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Largest supported CPU port count; sets the width of the port index.
  localparam int MAX_CPU = 4;

  // Width of the saturating host starvation counter.
  localparam int STARVE_W = 8;

  // Arbitration mode encodings for the RR_MODE parameter.
  localparam int RR_MODE_FIXED = 0;
  localparam int RR_MODE_RR    = 1;

  // Index of a CPU port (0..MAX_CPU-1).
  typedef logic [1:0] cpu_idx_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : One-hot round-robin select. The search starts at ptr and
//               wraps; ptr tied to zero gives fixed lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  cpu_idx_t     ptr,
  output logic [N-1:0] gnt
);

  logic found;
  int   idx;

  // Scan requests starting at the pointer; the first one found wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Single-port memory arbiter for NUM_CPU CPU ports plus one
//               host port. Host is lowest priority unless starved or the
//               CPUs are held; read data returns one cycle after the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CPU    = 2,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RR_MODE    = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic                       mips_cpu_clk,
  input  logic                       mips_cpu_resetn,
  input  logic                       cpu_hold,
  input  logic [NUM_CPU-1:0]         cpu_req,
  input  logic [NUM_CPU-1:0]         cpu_we,
  input  logic [NUM_CPU*ADDR_W-1:0]  cpu_addr,
  input  logic [NUM_CPU*DATA_W-1:0]  cpu_wdata,
  input  logic [NUM_CPU*DATA_W/8-1:0] cpu_wstrb,
  output logic [NUM_CPU-1:0]         cpu_gnt,
  output logic [NUM_CPU-1:0]         cpu_rvalid,
  output logic [DATA_W-1:0]          cpu_rdata,
  input  logic                       host_req,
  input  logic                       host_we,
  input  logic [ADDR_W-1:0]          host_addr,
  input  logic [DATA_W-1:0]          host_wdata,
  input  logic [DATA_W/8-1:0]        host_wstrb,
  output logic                       host_gnt,
  output logic                       host_rvalid,
  output logic [DATA_W-1:0]          host_rdata,
  output logic                       mem_en,
  output logic [DATA_W/8-1:0]        mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [NUM_CPU-1:0]  cpu_req_m;
  logic [NUM_CPU-1:0]  pick_gnt;
  cpu_idx_t            pick_ptr;
  cpu_idx_t            gnt_idx;
  logic                starved;
  logic                host_win;

  cpu_idx_t            ptr_q, ptr_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [NUM_CPU-1:0]  ret_cpu_q, ret_cpu_d;
  logic                ret_host_q, ret_host_d;

  // Mask CPU requests while the CPUs are held or the block is in reset.
  always_comb begin
    cpu_req_m = '0;
    if (mips_cpu_resetn && !cpu_hold) cpu_req_m = cpu_req;
  end

  assign pick_ptr = (RR_MODE == RR_MODE_RR) ? ptr_q : cpu_idx_t'(0);

  rr_picker #(
    .N (NUM_CPU)
  ) u_picker (
    .req (cpu_req_m),
    .ptr (pick_ptr),
    .gnt (pick_gnt)
  );

  // Grant decision: host wins when CPUs are held, host is starved, or no CPU asks.
  always_comb begin
    starved  = (starve_q == STARVE_W'(STARVE_MAX));
    host_win = mips_cpu_resetn && host_req &&
               (cpu_hold || starved || (cpu_req_m == '0));
    host_gnt = host_win;
    cpu_gnt  = host_win ? '0 : pick_gnt;
  end

  // Memory request mux from whichever port holds the grant.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    gnt_idx   = '0;
    if (host_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we ? host_wstrb : '0;
    end
    for (int i = 0; i < NUM_CPU; i++) begin
      if (cpu_gnt[i]) begin
        mem_en    = 1'b1;
        mem_addr  = cpu_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = cpu_wdata[i*DATA_W +: DATA_W];
        mem_we    = cpu_we[i] ? cpu_wstrb[i*STRB_W +: STRB_W] : '0;
        gnt_idx   = cpu_idx_t'(i);
      end
    end
  end

  // Next-state for the pointer, starvation counter and read-return register.
  always_comb begin
    ptr_d = ptr_q;
    if (cpu_gnt != '0) begin
      ptr_d = (gnt_idx == cpu_idx_t'(NUM_CPU - 1)) ? cpu_idx_t'(0) : gnt_idx + 1'b1;
    end
    starve_d = starve_q;
    if (!host_req || host_gnt) begin
      starve_d = '0;
    end else if (starve_q != '1) begin
      starve_d = starve_q + 1'b1;
    end
    ret_cpu_d  = cpu_gnt & ~cpu_we;
    ret_host_d = host_gnt & ~host_we;
  end

  // State registers; reset drops any pending read return.
  always_ff @(posedge mips_cpu_clk) begin
    if (!mips_cpu_resetn) begin
      ptr_q      <= '0;
      starve_q   <= '0;
      ret_cpu_q  <= '0;
      ret_host_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      starve_q   <= starve_d;
      ret_cpu_q  <= ret_cpu_d;
      ret_host_q <= ret_host_d;
    end
  end

  // Read return: steer memory data to the recorded winner, zero otherwise.
  always_comb begin
    cpu_rvalid  = ret_cpu_q;
    host_rvalid = ret_host_q;
    cpu_rdata   = (ret_cpu_q != '0) ? mem_rdata : '0;
    host_rdata  = ret_host_q ? mem_rdata : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               round-robin instance and a fixed-priority instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        rstn;
  logic        hold;
  logic [1:0]  cpu_req, cpu_we;
  logic [19:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic [7:0]  cpu_wstrb;
  logic        host_req, host_we;
  logic [9:0]  host_addr;
  logic [31:0] host_wdata;
  logic [3:0]  host_wstrb;

  logic [1:0]  cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [1:0]  fp_cpu_gnt, fp_cpu_rvalid;
  logic [31:0] fp_cpu_rdata;
  logic        fp_host_gnt, fp_host_rvalid;
  logic [31:0] fp_host_rdata;
  logic        fp_mem_en;
  logic [3:0]  fp_mem_we;
  logic [9:0]  fp_mem_addr;
  logic [31:0] fp_mem_wdata;
  logic [31:0] fp_mem_rdata;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .NUM_CPU(2), .ADDR_W(10), .DATA_W(32), .RR_MODE(1), .STARVE_MAX(3)
  ) dut (
    .mips_cpu_clk(clk), .mips_cpu_resetn(rstn), .cpu_hold(hold),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_wstrb(host_wstrb),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(
    .NUM_CPU(2), .ADDR_W(10), .DATA_W(32), .RR_MODE(0), .STARVE_MAX(3)
  ) dut_fp (
    .mips_cpu_clk(clk), .mips_cpu_resetn(rstn), .cpu_hold(hold),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_gnt(fp_cpu_gnt), .cpu_rvalid(fp_cpu_rvalid), .cpu_rdata(fp_cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_wstrb(host_wstrb),
    .host_gnt(fp_host_gnt), .host_rvalid(fp_host_rvalid), .host_rdata(fp_host_rdata),
    .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata)
  );

  assign fp_mem_rdata = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read, byte-writable memory model for the round-robin instance.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      if (mem_we == 4'h0) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
    mem[0] = 32'h11223344;
    mem[1] = 32'h11111111;
    mem[2] = 32'h22222222;
    mem_rdata = 32'h0;

    rstn = 1'b0; hold = 1'b0;
    cpu_req = 2'b11; cpu_we = 2'b00; cpu_addr = {10'd2, 10'd1};
    cpu_wdata = 64'h0; cpu_wstrb = 8'hFF;
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'd0;
    host_wdata = 32'h0; host_wstrb = 4'h0;

    // Reset: everything quiet, grants forced off while requests are present.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_cpu_gnt", cpu_gnt, 2'b00);
    chk("rst_host_gnt", host_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 4'h0);
    chk("rst_cpu_rvalid", cpu_rvalid, 2'b00);
    chk("rst_host_rvalid", host_rvalid, 1'b0);

    // Both CPUs reading continuously: grants alternate, rvalid one cycle later.
    @(negedge clk); rstn = 1'b1; host_req = 1'b0; #1;
    chk("rr_gnt0", cpu_gnt, 2'b01);
    chk("rr_addr0", mem_addr, 10'd1);
    chk("rr_rv0", cpu_rvalid, 2'b00);
    chk("fp_gnt0", fp_cpu_gnt, 2'b01);
    @(negedge clk); #1;
    chk("rr_gnt1", cpu_gnt, 2'b10);
    chk("rr_addr1", mem_addr, 10'd2);
    chk("rr_rv1", cpu_rvalid, 2'b01);
    chk("rr_rd1", cpu_rdata, 32'h11111111);
    chk("fp_gnt1", fp_cpu_gnt, 2'b01);
    @(negedge clk); #1;
    chk("rr_gnt2", cpu_gnt, 2'b10 ^ 2'b11);
    chk("rr_rv2", cpu_rvalid, 2'b10);
    chk("rr_rd2", cpu_rdata, 32'h22222222);
    chk("fp_gnt2", fp_cpu_gnt, 2'b01);
    @(negedge clk); #1;
    chk("rr_gnt3", cpu_gnt, 2'b10);
    chk("rr_rv3", cpu_rvalid, 2'b01);

    // Hold: host write wins immediately, CPU read return still completes.
    @(negedge clk);
    hold = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 10'd5;
    host_wdata = 32'hA5A5A5A5; host_wstrb = 4'hF; #1;
    chk("hold_host_gnt", host_gnt, 1'b1);
    chk("hold_cpu_gnt", cpu_gnt, 2'b00);
    chk("hold_mem_we", mem_we, 4'hF);
    chk("hold_mem_addr", mem_addr, 10'd5);
    chk("hold_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("hold_pend_rv", cpu_rvalid, 2'b10);
    chk("hold_pend_rd", cpu_rdata, 32'h22222222);

    // Starvation: CPU0 asks every cycle, host read waits three cycles then wins.
    @(negedge clk); hold = 1'b0; host_we = 1'b0; cpu_req = 2'b01; #1;
    chk("st_w1_host", host_gnt, 1'b0);
    chk("st_w1_cpu", cpu_gnt, 2'b01);
    chk("st_w1_hrv", host_rvalid, 1'b0);
    chk("st_w1_hrd", host_rdata, 32'h0);
    for (int w = 2; w <= 3; w++) begin
      @(negedge clk); #1;
      chk("st_wait_host", host_gnt, 1'b0);
      chk("st_wait_cpu", cpu_gnt, 2'b01);
    end
    @(negedge clk); #1;
    chk("st_w4_host", host_gnt, 1'b1);
    chk("st_w4_cpu", cpu_gnt, 2'b00);
    chk("st_w4_addr", mem_addr, 10'd5);
    @(negedge clk); #1;
    chk("st_clr_host", host_gnt, 1'b0);
    chk("st_clr_cpu", cpu_gnt, 2'b01);
    chk("st_hrv", host_rvalid, 1'b1);
    chk("st_hrd", host_rdata, 32'hA5A5A5A5);
    chk("st_crv", cpu_rvalid, 2'b00);

    // Byte write to addr 0 then read back the merged word.
    @(negedge clk);
    host_req = 1'b0; cpu_we = 2'b01; cpu_addr = {10'd2, 10'd0};
    cpu_wdata = {32'h0, 32'h0000BE00}; cpu_wstrb = {4'hF, 4'h2}; #1;
    chk("bw_gnt", cpu_gnt, 2'b01);
    chk("bw_mem_we", mem_we, 4'h2);
    chk("bw_prev_rv", cpu_rvalid, 2'b01);
    chk("bw_prev_rd", cpu_rdata, 32'h11111111);
    chk("bw_hrd_zero", host_rdata, 32'h0);
    @(negedge clk); cpu_we = 2'b00; #1;
    chk("br_gnt", cpu_gnt, 2'b01);
    chk("br_mem_we", mem_we, 4'h0);
    chk("br_wr_norv", cpu_rvalid, 2'b00);

    // CPU1 read granted, reset asserted before the next edge drops the return.
    @(negedge clk); cpu_req = 2'b10; #1;
    chk("br_rv", cpu_rvalid, 2'b01);
    chk("br_rd", cpu_rdata, 32'h1122BE44);
    chk("rs_gnt1", cpu_gnt, 2'b10);
    #2 rstn = 1'b0; cpu_req = 2'b11; #1;
    chk("rs_forced_gnt", cpu_gnt, 2'b00);
    @(negedge clk); #1;
    chk("rs_no_rv", cpu_rvalid, 2'b00);
    chk("rs_rd_zero", cpu_rdata, 32'h0);
    chk("rs_mem_en", mem_en, 1'b0);
    chk("rs_mem_we", mem_we, 4'h0);
    @(negedge clk); rstn = 1'b1; #1;
    chk("rs_post_gnt", cpu_gnt, 2'b01);
    chk("rs_post_rv", cpu_rvalid, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
